// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
//   ROB_SZ     : number of entries (power of two, >= 2)
//   ROB_TAG_W  : tag width; tag 0 means "no tag", entry i carries tag i+1
//   ROB_PTR_W  : head/tail pointer width
//   rob_entry_t: per-entry state {valid, complete, has_dest, dest_reg, value, pc}
package rob_pkg;

   localparam int unsigned ROB_SZ    = 8;
   localparam int unsigned ROB_TAG_W = $clog2(ROB_SZ + 1);
   localparam int unsigned ROB_PTR_W = $clog2(ROB_SZ);

   localparam logic [ROB_TAG_W-1:0] NO_TAG = '0;

   typedef struct packed {
      logic        valid;
      logic        complete;
      logic        has_dest;
      logic [4:0]  dest_reg;
      logic [31:0] value;
      logic [31:0] pc;
   } rob_entry_t;

   function automatic logic [ROB_TAG_W-1:0] ptr_to_tag(input logic [ROB_PTR_W-1:0] ptr);
      return ROB_TAG_W'(ptr) + ROB_TAG_W'(1);
   endfunction

   function automatic logic [ROB_PTR_W-1:0] tag_to_ptr(input logic [ROB_TAG_W-1:0] tag);
      logic [ROB_TAG_W-1:0] w_idx;
      w_idx = tag - ROB_TAG_W'(1);
      return w_idx[ROB_PTR_W-1:0];
   endfunction

   // Returns {ready, value}. A same-cycle CDB broadcast wins over the stored value.
   function automatic logic [32:0] read_operand(input logic [ROB_TAG_W-1:0] tag,
                                                input rob_entry_t           ent,
                                                input logic                 cdb_valid,
                                                input logic [ROB_TAG_W-1:0] cdb_tag,
                                                input logic [31:0]          cdb_value);
      if (tag == NO_TAG || tag > ROB_TAG_W'(ROB_SZ)) return '0;
      if (cdb_valid && cdb_tag == tag)               return {1'b1, cdb_value};
      if (ent.valid && ent.complete)                 return {1'b1, ent.value};
      return '0;
   endfunction

endpackage

// File: rtl/rob_ptr_ctr.sv
// Wrap-around pointer for the reorder buffer head/tail.
//   clock   : clock
//   reset   : synchronous, active-high reset (pointer -> 0)
//   i_clear : synchronous clear (pointer -> 0), used for squash
//   i_inc   : advance the pointer by one, wrapping DEPTH-1 -> 0
//   o_ptr   : current pointer value
module rob_ptr_ctr #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [PTR_W-1:0] o_ptr
);

   logic [PTR_W-1:0] r_ptr;

   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions, allocated in order at dispatch,
// completed by CDB broadcasts and retired in order from the head, one per cycle.
//   clock, reset             : clock, synchronous active-high reset
//   i_dispatch_*             : allocation request at the tail (valid, has_dest, dest_reg, pc)
//   i_squash                 : flush all entries (mispredict)
//   i_cdb_valid/tag/value    : completion broadcast
//   i_rd_tag_a/b             : operand lookup tags
//   o_rd_ready_a/b, value_a/b: forwarded operand (value 0 when not ready)
//   o_tail_tag, o_head_tag   : tag for the next dispatch / oldest entry (0 when empty)
//   o_full, o_empty, o_count : occupancy
//   o_retire_*               : head entry retiring this cycle
module rob
   import rob_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 i_dispatch_valid,
   input  logic                 i_dispatch_has_dest,
   input  logic [4:0]           i_dispatch_dest_reg,
   input  logic [31:0]          i_dispatch_pc,
   input  logic                 i_squash,
   input  logic                 i_cdb_valid,
   input  logic [ROB_TAG_W-1:0] i_cdb_tag,
   input  logic [31:0]          i_cdb_value,
   input  logic [ROB_TAG_W-1:0] i_rd_tag_a,
   input  logic [ROB_TAG_W-1:0] i_rd_tag_b,
   output logic                 o_rd_ready_a,
   output logic                 o_rd_ready_b,
   output logic [31:0]          o_rd_value_a,
   output logic [31:0]          o_rd_value_b,
   output logic [ROB_TAG_W-1:0] o_tail_tag,
   output logic [ROB_TAG_W-1:0] o_head_tag,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [ROB_TAG_W-1:0] o_count,
   output logic                 o_retire_valid,
   output logic [ROB_TAG_W-1:0] o_retire_tag,
   output logic                 o_retire_has_dest,
   output logic [4:0]           o_retire_dest_reg,
   output logic [31:0]          o_retire_value,
   output logic [31:0]          o_retire_pc
);

   rob_entry_t r_entries [ROB_SZ];
   rob_entry_t w_entries_next [ROB_SZ];
   logic [ROB_TAG_W-1:0] r_count;

   logic [ROB_PTR_W-1:0] w_head;
   logic [ROB_PTR_W-1:0] w_tail;
   logic [ROB_PTR_W-1:0] w_cdb_idx;
   logic                 w_accept;
   logic                 w_retire;
   logic                 w_cdb_hit;
   rob_entry_t           w_head_ent;
   logic [32:0]          w_rd_a;
   logic [32:0]          w_rd_b;

   assign w_head_ent = r_entries[w_head];
   assign o_full     = (r_count == ROB_TAG_W'(ROB_SZ));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;

   // Full blocks dispatch even when the head retires in the same cycle.
   assign w_accept = i_dispatch_valid && !o_full && !i_squash;
   assign w_retire = w_head_ent.valid && w_head_ent.complete && !i_squash && !reset;

   assign w_cdb_idx = tag_to_ptr(i_cdb_tag);
   assign w_cdb_hit = i_cdb_valid && (i_cdb_tag != NO_TAG) &&
                      (i_cdb_tag <= ROB_TAG_W'(ROB_SZ)) && r_entries[w_cdb_idx].valid;

   rob_ptr_ctr #(
      .DEPTH (ROB_SZ),
      .PTR_W (ROB_PTR_W)
   ) u_head_ptr (
      .clock   (clock),
      .reset   (reset),
      .i_clear (i_squash),
      .i_inc   (w_retire),
      .o_ptr   (w_head)
   );

   rob_ptr_ctr #(
      .DEPTH (ROB_SZ),
      .PTR_W (ROB_PTR_W)
   ) u_tail_ptr (
      .clock   (clock),
      .reset   (reset),
      .i_clear (i_squash),
      .i_inc   (w_accept),
      .o_ptr   (w_tail)
   );

   // Dispatch, completion and retirement never collide harmfully: a dispatch target is not
   // yet valid so the CDB ignores it, and the retire clear is applied last.
   always_comb begin
      for (int i = 0; i < int'(ROB_SZ); i++) begin
         w_entries_next[i] = r_entries[i];
      end
      if (w_accept) begin
         w_entries_next[w_tail].valid    = 1'b1;
         w_entries_next[w_tail].complete = 1'b0;
         w_entries_next[w_tail].has_dest = i_dispatch_has_dest;
         w_entries_next[w_tail].dest_reg = i_dispatch_dest_reg;
         w_entries_next[w_tail].value    = '0;
         w_entries_next[w_tail].pc       = i_dispatch_pc;
      end
      if (w_cdb_hit) begin
         w_entries_next[w_cdb_idx].complete = 1'b1;
         w_entries_next[w_cdb_idx].value    = i_cdb_value;
      end
      if (w_retire) begin
         w_entries_next[w_head] = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || i_squash) begin
         for (int i = 0; i < int'(ROB_SZ); i++) begin
            r_entries[i] <= '0;
         end
         r_count <= '0;
      end else begin
         for (int i = 0; i < int'(ROB_SZ); i++) begin
            r_entries[i] <= w_entries_next[i];
         end
         case ({w_accept, w_retire})
            2'b10:   r_count <= r_count + ROB_TAG_W'(1);
            2'b01:   r_count <= r_count - ROB_TAG_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_rd_a = read_operand(i_rd_tag_a, r_entries[tag_to_ptr(i_rd_tag_a)],
                                i_cdb_valid, i_cdb_tag, i_cdb_value);
   assign w_rd_b = read_operand(i_rd_tag_b, r_entries[tag_to_ptr(i_rd_tag_b)],
                                i_cdb_valid, i_cdb_tag, i_cdb_value);

   assign o_rd_ready_a = w_rd_a[32];
   assign o_rd_value_a = w_rd_a[31:0];
   assign o_rd_ready_b = w_rd_b[32];
   assign o_rd_value_b = w_rd_b[31:0];

   assign o_tail_tag = ptr_to_tag(w_tail);
   assign o_head_tag = w_head_ent.valid ? ptr_to_tag(w_head) : NO_TAG;

   assign o_retire_valid    = w_retire;
   assign o_retire_tag      = ptr_to_tag(w_head);
   assign o_retire_has_dest = w_head_ent.has_dest;
   assign o_retire_dest_reg = w_head_ent.dest_reg;
   assign o_retire_value    = w_head_ent.value;
   assign o_retire_pc       = w_head_ent.pc;

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for rob: expected retirements are queued at dispatch and
// compared in order whenever the DUT retires.
module tb_rob;

   localparam int TW = 4;

   logic          clock;
   logic          reset;
   logic          dv, dhd, sq, cv;
   logic [4:0]    ddst;
   logic [31:0]   dpc, cval;
   logic [TW-1:0] ct, ra, rb;
   logic          rdy_a, rdy_b, full, empty, ret_v, ret_hd;
   logic [31:0]   val_a, val_b, ret_val, ret_pc;
   logic [TW-1:0] tail_tag, head_tag, count, ret_tag;
   logic [4:0]    ret_dst;

   typedef struct {
      int          tag;
      logic        has_dest;
      logic [4:0]  dest;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp_val [16];
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_ret = 0;

   rob dut (
      .clock               (clock),
      .reset               (reset),
      .i_dispatch_valid    (dv),
      .i_dispatch_has_dest (dhd),
      .i_dispatch_dest_reg (ddst),
      .i_dispatch_pc       (dpc),
      .i_squash            (sq),
      .i_cdb_valid         (cv),
      .i_cdb_tag           (ct),
      .i_cdb_value         (cval),
      .i_rd_tag_a          (ra),
      .i_rd_tag_b          (rb),
      .o_rd_ready_a        (rdy_a),
      .o_rd_ready_b        (rdy_b),
      .o_rd_value_a        (val_a),
      .o_rd_value_b        (val_b),
      .o_tail_tag          (tail_tag),
      .o_head_tag          (head_tag),
      .o_full              (full),
      .o_empty             (empty),
      .o_count             (count),
      .o_retire_valid      (ret_v),
      .o_retire_tag        (ret_tag),
      .o_retire_has_dest   (ret_hd),
      .o_retire_dest_reg   (ret_dst),
      .o_retire_value      (ret_val),
      .o_retire_pc         (ret_pc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic dispatch(input int tag, input logic [31:0] pc);
      dv   = 1'b1;
      dhd  = tag[0];
      ddst = 5'(tag);
      dpc  = pc;
      #1;
      chk("disp_tail_tag", 32'(tail_tag), 32'(tag));
      sb.push_back('{tag: tag, has_dest: tag[0], dest: 5'(tag), pc: pc});
      tick();
      dv = 1'b0;
   endtask

   // Retirement monitor: in-order scoreboard check on every retiring cycle.
   always @(negedge clock) begin
      if (ret_v === 1'b1) begin
         n_ret++;
         if (sb.size() == 0) begin
            chk("retire_unexpected", 32'(ret_tag), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("retire_tag", 32'(ret_tag), 32'(e.tag));
            chk("retire_has_dest", 32'(ret_hd), 32'(e.has_dest));
            chk("retire_dest", 32'(ret_dst), 32'(e.dest));
            chk("retire_pc", ret_pc, e.pc);
            chk("retire_value", ret_val, exp_val[e.tag]);
         end
      end
   end

   initial begin
      reset = 1'b1;
      {dv, dhd, sq, cv} = '0;
      ddst = '0; dpc = '0; cval = '0; ct = '0; ra = 4'd3; rb = '0;
      for (int i = 0; i < 16; i++) exp_val[i] = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      // Reset state
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_tail_tag", 32'(tail_tag), 1);
      chk("rst_head_tag", 32'(head_tag), 0);
      chk("rst_retire_valid", 32'(ret_v), 0);
      chk("rst_rd_ready_a", 32'(rdy_a), 0);
      chk("rst_rd_value_a", val_a, 0);

      // Fill all 8 entries, then a 9th dispatch must be ignored
      for (int i = 1; i <= 8; i++) dispatch(i, 32'h1000 + 32'(4 * i));
      dv = 1'b1; ddst = 5'd9; dpc = 32'h1999;
      #1;
      chk("fill_full", 32'(full), 1);
      chk("fill_count", 32'(count), 8);
      tick();
      dv = 1'b0;
      #1;
      chk("ninth_count", 32'(count), 8);
      chk("ninth_head_tag", 32'(head_tag), 1);

      // Out-of-order completion, in-order retirement
      cv = 1'b1; ct = 4'd2; cval = 32'h22; exp_val[2] = 32'h22;
      tick();
      ct = 4'd1; cval = 32'h11; exp_val[1] = 32'h11;
      #1;
      chk("no_early_retire", 32'(ret_v), 0);
      tick();
      cv = 1'b0;
      #1;
      chk("retire1_valid", 32'(ret_v), 1);
      chk("retire1_tag", 32'(ret_tag), 1);
      tick();
      #1;
      chk("retire2_valid", 32'(ret_v), 1);
      chk("retire2_tag", 32'(ret_tag), 2);
      tick();
      #1;
      chk("after_retire_count", 32'(count), 6);
      chk("after_retire_idle", 32'(ret_v), 0);

      // CDB bypass to operand read, then stored value
      cv = 1'b1; ct = 4'd3; cval = 32'h33; exp_val[3] = 32'h33; ra = 4'd3; rb = 4'd4;
      #1;
      chk("bypass_ready_a", 32'(rdy_a), 1);
      chk("bypass_value_a", val_a, 32'h33);
      chk("notready_b", 32'(rdy_b), 0);
      chk("notready_value_b", val_b, 0);
      tick();
      cv = 1'b0;
      #1;
      chk("stored_ready_a", 32'(rdy_a), 1);
      chk("stored_value_a", val_a, 32'h33);
      chk("retire3_tag", 32'(ret_tag), 3);
      tick();
      #1;
      chk("count5", 32'(count), 5);

      // Drain tags 4..8 back-to-back
      for (int t = 4; t <= 8; t++) begin
         cv = 1'b1; ct = 4'(t); cval = 32'h40 + 32'(t); exp_val[t] = 32'h40 + 32'(t);
         tick();
      end
      cv = 1'b0;
      tick();
      #1;
      chk("drain_empty", 32'(empty), 1);
      chk("drain_head_tag", 32'(head_tag), 0);

      // Full + retire + dispatch: rejected, then accepted with wrapped tag 1
      for (int i = 1; i <= 8; i++) dispatch(i, 32'h2000 + 32'(4 * i));
      cv = 1'b1; ct = 4'd1; cval = 32'hA1; exp_val[1] = 32'hA1;
      tick();
      cv = 1'b0; dv = 1'b1; dhd = 1'b0; ddst = 5'd9; dpc = 32'h3000;
      #1;
      chk("fr_retire_valid", 32'(ret_v), 1);
      chk("fr_full", 32'(full), 1);
      tick();
      #1;
      chk("fr_rejected_count", 32'(count), 7);
      chk("fr_tail_tag", 32'(tail_tag), 1);
      sb.push_back('{tag: 1, has_dest: 1'b0, dest: 5'd9, pc: 32'h3000});
      tick();
      dv = 1'b0;
      #1;
      chk("fr_accepted_count", 32'(count), 8);
      chk("fr_tail_tag_next", 32'(tail_tag), 2);

      // Flush everything
      sq = 1'b1;
      tick();
      sq = 1'b0;
      sb.delete();
      #1;
      chk("flush_empty", 32'(empty), 1);

      // 4 entries with complete head; squash overrides retire and dispatch
      for (int i = 1; i <= 4; i++) dispatch(i, 32'h4000 + 32'(4 * i));
      cv = 1'b1; ct = 4'd1; cval = 32'h55; exp_val[1] = 32'h55;
      tick();
      cv = 1'b0; sq = 1'b1; dv = 1'b1; ra = 4'd1;
      #1;
      chk("sq_retire_valid", 32'(ret_v), 0);
      chk("sq_head_tag", 32'(head_tag), 1);
      tick();
      sq = 1'b0; dv = 1'b0;
      sb.delete();
      #1;
      chk("sq_empty", 32'(empty), 1);
      chk("sq_count", 32'(count), 0);
      chk("sq_tail_tag", 32'(tail_tag), 1);
      chk("sq_rd_ready_a", 32'(rdy_a), 0);

      // Tag 0 and invalid-entry broadcasts are ignored
      dispatch(1, 32'h5000);
      cv = 1'b1; ct = 4'd0; cval = 32'h99; ra = 4'd0;
      #1;
      chk("tag0_ready", 32'(rdy_a), 0);
      chk("tag0_value", val_a, 0);
      tick();
      ct = 4'd2;
      tick();
      cv = 1'b0; ra = 4'd2; rb = 4'd1;
      #1;
      chk("invalid_ready_a", 32'(rdy_a), 0);
      chk("tag1_not_ready", 32'(rdy_b), 0);
      chk("no_spurious_retire", 32'(ret_v), 0);

      // Reset mid-operation: completed head must not retire in the reset cycle
      cv = 1'b1; ct = 4'd1; cval = 32'h66; exp_val[1] = 32'h66;
      tick();
      cv = 1'b0; reset = 1'b1;
      #1;
      chk("rst_mid_retire", 32'(ret_v), 0);
      tick();
      reset = 1'b0;
      sb.delete();
      #1;
      chk("rst_mid_empty", 32'(empty), 1);
      chk("rst_mid_count", 32'(count), 0);
      tick();

      chk("total_retired", 32'(n_ret), 9);
      chk("scoreboard_drained", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
